// File: rtl/riscv_mem_port_arbiter.sv
// ============================================================================
// Module      : riscv_mem_port_arbiter
// Description : Memory-port controller between P_NUM_CH core request channels
//               (ch0 = instruction fetch, ch1 = data, further masters optional)
//               and one synchronous-read SRAM port. Arbitrates one request at
//               a time, inserts P_WAIT_CYCLES wait states before the access,
//               and returns a one-cycle ch_ready pulse plus read data to the
//               granted channel.
//
//               Transaction sequence: IDLE (grant + latch) -> WAIT (x W) ->
//               ACCESS (mem_en) -> RESP (ch_ready) -> IDLE.
//
// Ports       : clk        - clock, all logic on posedge
//               reset      - synchronous, active-low reset
//               ch_req     - per-channel request
//               ch_we      - per-channel write (1) / read (0)
//               ch_be      - per-channel byte enables, channel i at slice i
//               ch_addr    - per-channel address, channel i at slice i
//               ch_wdata   - per-channel write data
//               ch_rdata   - per-channel read data (held between reads)
//               ch_ready   - per-channel one-cycle completion pulse
//               mem_en     - SRAM access strobe (ACCESS cycle only)
//               mem_we     - SRAM write enable (ACCESS cycle only)
//               mem_be     - SRAM byte enables (latched)
//               mem_addr   - SRAM address (latched)
//               mem_wdata  - SRAM write data (latched)
//               mem_rdata  - SRAM read data, valid the cycle after mem_en
//
// Options     : RISCV_MEM_RR_EN defined   -> round-robin arbitration
//               RISCV_MEM_RR_EN undefined -> fixed priority, lowest index wins
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_port_arbiter #(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_ADDR_WIDTH  = 32,
    parameter int P_NUM_CH      = 2,
    parameter int P_WAIT_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [P_NUM_CH-1:0]                ch_req,
    input  logic [P_NUM_CH-1:0]                ch_we,
    input  logic [P_NUM_CH*P_DATA_WIDTH/8-1:0] ch_be,
    input  logic [P_NUM_CH*P_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [P_NUM_CH*P_DATA_WIDTH-1:0]   ch_wdata,
    output logic [P_NUM_CH*P_DATA_WIDTH-1:0]   ch_rdata,
    output logic [P_NUM_CH-1:0]                ch_ready,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [P_DATA_WIDTH/8-1:0]          mem_be,
    output logic [P_ADDR_WIDTH-1:0]            mem_addr,
    output logic [P_DATA_WIDTH-1:0]            mem_wdata,
    input  logic [P_DATA_WIDTH-1:0]            mem_rdata
);

    localparam int c_BE_W  = P_DATA_WIDTH / 8;
    localparam int c_IDX_W = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;
    // A zero-wait build still needs a 1-bit counter so the declaration is legal.
    localparam int c_CNT_W = (P_WAIT_CYCLES > 0) ? $clog2(P_WAIT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD =
        c_CNT_W'((P_WAIT_CYCLES > 0) ? P_WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_grant;
    logic                  w_mem_en;
    logic                  w_mem_we;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_gnt;
    logic                  r_we;
    logic [c_BE_W-1:0]     r_be;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_DATA_WIDTH-1:0] r_wdata;
    logic [P_NUM_CH*P_DATA_WIDTH-1:0] r_rdata;

    logic                  w_any;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic                  w_sel_we;
    logic [c_BE_W-1:0]     w_sel_be;
    logic [P_ADDR_WIDTH-1:0] w_sel_addr;
    logic [P_DATA_WIDTH-1:0] w_sel_wdata;
    logic [P_NUM_CH-1:0]   w_ready;

    assign w_any = |ch_req;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef RISCV_MEM_RR_EN
    logic [c_IDX_W-1:0] r_rr_ptr;

    // Round robin without a modulo: scanning downward, the last requester seen
    // is the lowest index overall (wrap candidate) and the last one seen above
    // the pointer is the first channel after the previous grant.
    always_comb begin
        logic                v_hi_found;
        logic [c_IDX_W-1:0]  v_hi;
        logic [c_IDX_W-1:0]  v_lo;
        v_hi_found = 1'b0;
        v_hi       = '0;
        v_lo       = '0;
        for (int i = P_NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                v_lo = c_IDX_W'(i);
                if (c_IDX_W'(i) > r_rr_ptr) begin
                    v_hi       = c_IDX_W'(i);
                    v_hi_found = 1'b1;
                end
            end
        end
        w_gnt_idx = v_hi_found ? v_hi : v_lo;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // Pointing at the last channel makes ch0 the first winner.
            r_rr_ptr <= c_IDX_W'(P_NUM_CH - 1);
        end else if (w_grant) begin
            r_rr_ptr <= w_gnt_idx;
        end
    end
`else
    always_comb begin
        w_gnt_idx = '0;
        for (int i = P_NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                w_gnt_idx = c_IDX_W'(i);
            end
        end
    end
`endif

    // Request fields of the winning channel.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < P_NUM_CH; i++) begin
            if (w_gnt_idx == c_IDX_W'(i)) begin
                w_sel_we    = ch_we[i];
                w_sel_be    = ch_be[i*c_BE_W +: c_BE_W];
                w_sel_addr  = ch_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                w_sel_wdata = ch_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (P_WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_en    = 1'b1;
                w_mem_we    = r_we;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: latched request, wait counter, per-channel read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_gnt   <= w_gnt_idx;
                r_we    <= w_sel_we;
                r_be    <= w_sel_be;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_cnt   <= c_WAIT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // Capture the response so it stays visible after the RESP cycle.
            if (r_state == S_RESP && !r_we) begin
                for (int i = 0; i < P_NUM_CH; i++) begin
                    if (r_gnt == c_IDX_W'(i)) begin
                        r_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH] <= mem_rdata;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < P_NUM_CH; gi++) begin : g_ch
            assign w_ready[gi] = (r_state == S_RESP) && (r_gnt == c_IDX_W'(gi));
            // During RESP the SRAM output is forwarded directly so the core
            // sees read data in the same cycle as ready.
            assign ch_rdata[gi*P_DATA_WIDTH +: P_DATA_WIDTH] =
                (w_ready[gi] && !r_we) ? mem_rdata
                                       : r_rdata[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    endgenerate

    assign ch_ready = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_riscv_mem_port_arbiter
// Description : Self-checking bench for riscv_mem_port_arbiter. Instance A
//               uses two channels and two wait states; instance B uses zero
//               wait states. A word-array scoreboard tracks expected memory
//               contents, expected held read data per channel and the last
//               granted channel; expected latencies follow W directly.
//               Arbitration expectations follow RISCV_MEM_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NCH = 2;
    localparam int BW  = DW / 8;
    localparam int TW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic fill;

    // Instance A (W = TW)
    logic [NCH-1:0]    ch_req, ch_we, ch_ready;
    logic [NCH*BW-1:0] ch_be;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata, ch_rdata;
    logic              mem_en, mem_we;
    logic [BW-1:0]     mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;

    // Instance B (W = 0)
    logic [NCH-1:0]    b_ch_req, b_ch_we, b_ch_ready;
    logic [NCH*BW-1:0] b_ch_be;
    logic [NCH*AW-1:0] b_ch_addr;
    logic [NCH*DW-1:0] b_ch_wdata, b_ch_rdata;
    logic              b_mem_en, b_mem_we;
    logic [BW-1:0]     b_mem_be;
    logic [AW-1:0]     b_mem_addr;
    logic [DW-1:0]     b_mem_wdata, b_mem_rdata;

    riscv_mem_port_arbiter #(
        .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_NUM_CH(NCH), .P_WAIT_CYCLES(TW)
    ) dut (
        .clk(clk), .reset(rst_n),
        .ch_req(ch_req), .ch_we(ch_we), .ch_be(ch_be), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ready(ch_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    riscv_mem_port_arbiter #(
        .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_NUM_CH(NCH), .P_WAIT_CYCLES(0)
    ) dut_w0 (
        .clk(clk), .reset(rst_n),
        .ch_req(b_ch_req), .ch_we(b_ch_we), .ch_be(b_ch_be), .ch_addr(b_ch_addr),
        .ch_wdata(b_ch_wdata), .ch_rdata(b_ch_rdata), .ch_ready(b_ch_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i) * 32'h9E37_79B9 + 32'h0000_1234;
    endfunction

    // SRAM models (256 words, word index = addr[9:2])
    logic [DW-1:0] sram   [0:255];
    logic [DW-1:0] sram_b [0:255];
    logic          pl_en;
    logic [7:0]    pl_idx;
    logic [DW-1:0] pl_val;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
        end else if (pl_en) begin
            sram[pl_idx] <= pl_val;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) sram_b[i] <= init_word(i);
        end else if (b_mem_en) begin
            if (b_mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (b_mem_be[b]) sram_b[b_mem_addr[9:2]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
            end else begin
                b_mem_rdata <= sram_b[b_mem_addr[9:2]];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] exp_mem [0:255];
    logic [DW-1:0] exp_rd  [0:NCH-1];
    int            last_gnt;
    int            n_vec;
    int            n_err;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Which requester wins, given the request mask and the previous winner.
    function automatic int pick(input logic [NCH-1:0] m, input int last);
`ifdef RISCV_MEM_RR_EN
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (last + k) % NCH;
            if (m[c]) return c;
        end
`else
        for (int c = 0; c < NCH; c++)
            if (m[c]) return c;
`endif
        return -1;
    endfunction

    task automatic preload(input int idx, input logic [DW-1:0] val);
        pl_en  = 1'b1;
        pl_idx = 8'(idx);
        pl_val = val;
        exp_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One isolated transaction on instance A; the request is dropped right
    // after the grant cycle, which must not abort it.
    task automatic run_txn(input int ch, input logic we, input logic [BW-1:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int            idx;
        logic [DW-1:0] exp_read;
        logic [NCH-1:0] exp_rdy;
        idx      = int'(addr[9:2]);
        exp_read = exp_mem[idx];
        ch_req = '0;
        ch_req[ch] = 1'b1;
        ch_we[ch]  = we;
        ch_be[ch*BW +: BW]    = be;
        ch_addr[ch*AW +: AW]  = addr;
        ch_wdata[ch*DW +: DW] = wd;
        if (we) exp_mem[idx] = merge(exp_read, wd, be);
        else    exp_rd[ch]   = exp_read;
        last_gnt = ch;
        for (int c = 1; c <= TW + 3; c++) begin
            @(negedge clk);
            if (c == 1) ch_req = '0;
            n_vec++;
            if (mem_en !== (c == TW + 1)) begin
                n_err++;
                $display("FAIL txn_mem_en ch%0d cycle %0d: got %b expected %b", ch, c, mem_en, (c == TW + 1));
            end
            if (c == TW + 1) begin
                n_vec++;
                if ({mem_we, mem_be, mem_addr} !== {we, be, addr}) begin
                    n_err++;
                    $display("FAIL txn_mem_ctrl ch%0d: got we=%b be=%h addr=%h expected we=%b be=%h addr=%h",
                             ch, mem_we, mem_be, mem_addr, we, be, addr);
                end
                if (we) begin
                    n_vec++;
                    if (mem_wdata !== wd) begin
                        n_err++;
                        $display("FAIL txn_mem_wdata ch%0d: got %h expected %h", ch, mem_wdata, wd);
                    end
                end
            end
            exp_rdy = '0;
            if (c == TW + 2) exp_rdy[ch] = 1'b1;
            n_vec++;
            if (ch_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL txn_ready ch%0d cycle %0d: got %b expected %b", ch, c, ch_ready, exp_rdy);
            end
            if (c >= TW + 2) begin
                n_vec++;
                if (ch_rdata[ch*DW +: DW] !== exp_rd[ch]) begin
                    n_err++;
                    $display("FAIL txn_rdata ch%0d cycle %0d: got %h expected %h", ch, c, ch_rdata[ch*DW +: DW], exp_rd[ch]);
                end
            end
        end
        for (int o = 0; o < NCH; o++) begin
            if (o != ch) begin
                n_vec++;
                if (ch_rdata[o*DW +: DW] !== exp_rd[o]) begin
                    n_err++;
                    $display("FAIL txn_other_rdata ch%0d: got %h expected %h", o, ch_rdata[o*DW +: DW], exp_rd[o]);
                end
            end
        end
    endtask

    task automatic test_reset();
        int g;
        logic [NCH-1:0] exp_rdy;
        rst_n  = 1'b0;
        fill   = 1'b1;
        ch_req = 2'b11;
        ch_we  = '0;
        ch_be  = '1;
        ch_addr = {32'h0000_0044, 32'h0000_0000};
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n_vec++;
            if ({ch_ready, ch_rdata} !== '0) begin
                n_err++;
                $display("FAIL reset_ch_outputs: got %h expected 0", {ch_ready, ch_rdata});
            end
            n_vec++;
            if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
                n_err++;
                $display("FAIL reset_mem_outputs: got %h expected 0", {mem_en, mem_we, mem_be, mem_addr, mem_wdata});
            end
            n_vec++;
            if ({b_ch_ready, b_ch_rdata, b_mem_en, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata} !== '0) begin
                n_err++;
                $display("FAIL reset_w0_outputs: got %h expected 0",
                         {b_ch_ready, b_ch_rdata, b_mem_en, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata});
            end
        end
        // Release with both channels requesting: ch0 must win first.
        fill  = 1'b0;
        rst_n = 1'b1;
        g = pick(2'b11, last_gnt);
        exp_rd[g] = exp_mem[int'(ch_addr[g*AW + 2 +: 8])];
        last_gnt = g;
        for (int c = 1; c <= TW + 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (mem_en !== (c == TW + 1)) begin
                n_err++;
                $display("FAIL reset_first_mem_en cycle %0d: got %b expected %b", c, mem_en, (c == TW + 1));
            end
            if (c == TW + 1) begin
                n_vec++;
                if (mem_addr !== ch_addr[g*AW +: AW]) begin
                    n_err++;
                    $display("FAIL reset_first_grant_addr: got %h expected %h", mem_addr, ch_addr[g*AW +: AW]);
                end
            end
            exp_rdy = '0;
            if (c == TW + 2) exp_rdy[g] = 1'b1;
            n_vec++;
            if (ch_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL reset_first_ready cycle %0d: got %b expected %b", c, ch_ready, exp_rdy);
            end
            if (c == TW + 2) begin
                n_vec++;
                if (ch_rdata[g*DW +: DW] !== exp_rd[g]) begin
                    n_err++;
                    $display("FAIL reset_first_rdata: got %h expected %h", ch_rdata[g*DW +: DW], exp_rd[g]);
                end
                ch_req = '0;
            end
        end
    endtask

    task automatic test_read_w2();
        preload(16, 32'hDEAD_BEEF);
        run_txn(1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (ch_rdata[DW +: DW] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL read_hold: got %h expected deadbeef", ch_rdata[DW +: DW]);
        end
    endtask

    task automatic test_write_be();
        preload(4, 32'hAAAA_AAAA);
        run_txn(1, 1'b1, 4'b0011, 32'h0000_0010, 32'h1234_5678);
        run_txn(1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        n_vec++;
        if (ch_rdata[DW +: DW] !== 32'hAAAA_5678) begin
            n_err++;
            $display("FAIL write_be_readback: got %h expected aaaa5678", ch_rdata[DW +: DW]);
        end
    endtask

    task automatic test_zero_be();
        run_txn(0, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF);
        run_txn(0, 1'b0, 4'b0000, 32'h0000_0020, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int            ch;
            logic          we;
            logic [BW-1:0] be;
            logic [AW-1:0] addr;
            logic [DW-1:0] wd;
            ch   = int'($urandom_range(0, NCH - 1));
            we   = 1'($urandom_range(0, 1));
            be   = BW'($urandom);
            addr = AW'($urandom_range(0, 255)) << 2;
            wd   = $urandom;
            run_txn(ch, we, be, addr, wd);
        end
    endtask

    // Both channels request continuously for four back-to-back transactions.
    task automatic test_contention();
        int             g [0:3];
        int             l;
        int             k;
        int             ph;
        logic [NCH-1:0] exp_rdy;
        preload(8, $urandom);
        preload(9, $urandom);
        l = last_gnt;
        for (int i = 0; i < 4; i++) begin
            g[i] = pick(2'b11, l);
            l = g[i];
        end
        ch_we   = '0;
        ch_be   = '1;
        ch_addr = {32'h0000_0024, 32'h0000_0020};
        ch_req  = 2'b11;
        for (int c = 1; c <= 4 * (3 + TW); c++) begin
            @(negedge clk);
            k  = (c - 1) / (3 + TW);
            ph = (c - 1) % (3 + TW);
            n_vec++;
            if (mem_en !== (ph == TW)) begin
                n_err++;
                $display("FAIL contention_mem_en cycle %0d: got %b expected %b", c, mem_en, (ph == TW));
            end
            exp_rdy = '0;
            if (ph == TW + 1) exp_rdy[g[k]] = 1'b1;
            n_vec++;
            if (ch_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL contention_ready txn %0d cycle %0d: got %b expected %b", k, c, ch_ready, exp_rdy);
            end
            if (ph == TW + 1) begin
                exp_rd[g[k]] = exp_mem[8 + g[k]];
                n_vec++;
                if (ch_rdata[g[k]*DW +: DW] !== exp_rd[g[k]]) begin
                    n_err++;
                    $display("FAIL contention_rdata txn %0d: got %h expected %h", k, ch_rdata[g[k]*DW +: DW], exp_rd[g[k]]);
                end
                if (k == 3) ch_req = '0;
            end
        end
        last_gnt = g[3];
    endtask

    // Reset while the request is still in its wait states.
    task automatic test_reset_mid();
        ch_req = 2'b01;
        ch_we[0] = 1'b0;
        ch_addr[AW-1:0] = 32'h0000_0080;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        ch_req = '0;
        for (int i = 0; i < NCH; i++) exp_rd[i] = '0;
        last_gnt = NCH - 1;
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if ({mem_en, ch_ready} !== '0) begin
                n_err++;
                $display("FAIL reset_mid_quiet step %0d: got en=%b ready=%b expected 0", c, mem_en, ch_ready);
            end
            @(negedge clk);
        end
        n_vec++;
        if (ch_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_mid_rdata: got %h expected 0", ch_rdata);
        end
        run_txn(0, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
    endtask

    task automatic test_w0();
        logic [DW-1:0] exp_w;
        exp_w = init_word(2);
        b_ch_req = 2'b01;
        b_ch_we  = '0;
        b_ch_be  = '1;
        b_ch_addr[AW-1:0] = 32'h0000_0008;
        @(negedge clk);
        b_ch_req = '0;
        n_vec++;
        if ({b_mem_en, b_mem_we, b_mem_addr, b_ch_ready} !== {1'b1, 1'b0, 32'h0000_0008, 2'b00}) begin
            n_err++;
            $display("FAIL w0_access: got en=%b we=%b addr=%h ready=%b expected en=1 we=0 addr=00000008 ready=00",
                     b_mem_en, b_mem_we, b_mem_addr, b_ch_ready);
        end
        @(negedge clk);
        n_vec++;
        if ({b_mem_en, b_ch_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL w0_ready: got en=%b ready=%b expected en=0 ready=01", b_mem_en, b_ch_ready);
        end
        n_vec++;
        if (b_ch_rdata[DW-1:0] !== exp_w) begin
            n_err++;
            $display("FAIL w0_rdata: got %h expected %h", b_ch_rdata[DW-1:0], exp_w);
        end
        @(negedge clk);
        n_vec++;
        if ({b_mem_en, b_ch_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL w0_after: got en=%b ready=%b expected 0", b_mem_en, b_ch_ready);
        end
        n_vec++;
        if (b_ch_rdata[DW-1:0] !== exp_w) begin
            n_err++;
            $display("FAIL w0_rdata_hold: got %h expected %h", b_ch_rdata[DW-1:0], exp_w);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_gnt = NCH - 1;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
        for (int i = 0; i < NCH; i++) exp_rd[i] = '0;
        rst_n      = 1'b0;
        fill       = 1'b1;
        pl_en      = 1'b0;
        pl_idx     = '0;
        pl_val     = '0;
        ch_req     = '0;
        ch_we      = '0;
        ch_be      = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        b_ch_req   = '0;
        b_ch_we    = '0;
        b_ch_be    = '0;
        b_ch_addr  = '0;
        b_ch_wdata = '0;

        test_reset();
        test_read_w2();
        test_write_be();
        test_zero_be();
        test_random();
        test_contention();
        test_reset_mid();
        test_w0();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_mem_port_arbiter.md
# riscv_mem_port_arbiter

Parametrised memory-port controller between the RISC-V core's memory-request channels (instruction fetch, data load/store, optional extra masters) and a single synchronous-read SRAM port. It arbitrates among P_NUM_CH request channels and inserts a programmable number of wait states. It generates the per-channel `ready` handshake and byte-lane enables that the core and the testbench memory interface expect. It is the RTL counterpart of the bench's instruction and data memory signalling, generalised to N channels and variable latency.

## Interface
- P_DATA_WIDTH, 32, data bus width; must be a multiple of 8
- P_ADDR_WIDTH, 32, address width for every channel and the memory port
- P_NUM_CH, 2, number of request channels (ch0 = instruction, ch1 = data); range 1..8
- P_WAIT_CYCLES, 1, wait states inserted before each memory access; range 0..255
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low reset (0 = reset)
- ch_req  in  P_NUM_CH  per-channel request
- ch_we  in  P_NUM_CH  per-channel write (1) / read (0)
- ch_be  in  P_NUM_CH*P_DATA_WIDTH/8  byte-lane enables, channel i at slice i
- ch_addr  in  P_NUM_CH*P_ADDR_WIDTH  request address, channel i at slice i
- ch_wdata  in  P_NUM_CH*P_DATA_WIDTH  write data
- ch_rdata  out  P_NUM_CH*P_DATA_WIDTH  read data per channel
- ch_ready  out  P_NUM_CH  one-cycle completion pulse per channel
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_be  out  P_DATA_WIDTH/8  SRAM byte enables
- mem_addr  out  P_ADDR_WIDTH  SRAM address
- mem_wdata  out  P_DATA_WIDTH  SRAM write data
- mem_rdata  in  P_DATA_WIDTH  SRAM read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if any ch_req is high, grant one channel and latch its we/be/addr/wdata into the memory-side registers. Go to WAIT if P_WAIT_CYCLES>0, else go to ACCESS. With no request, stay in IDLE.
- WAIT: the counter loads P_WAIT_CYCLES-1 on grant and decrements each cycle. Leave for ACCESS when it reaches 0. Counter width is $clog2(P_WAIT_CYCLES+1).
- ACCESS: exactly one cycle. mem_en=1, mem_we=latched we, then go to RESP.
- RESP: ch_ready[g]=1 for the granted channel only. ch_rdata[g] = mem_rdata combinationally for reads. The per-channel rdata register captures that value at the end of RESP and holds it until the next read on that channel. Writes leave ch_rdata[g] unchanged. Next state is IDLE.
- mem_addr, mem_be and mem_wdata hold their latched values outside ACCESS. mem_en and mem_we are 0 outside ACCESS.
- Requester rule: hold req/we/be/addr/wdata until ch_ready. Deasserting ch_req after grant does not abort; the transaction completes and ready still pulses.
- req held high after ready is a new request, sampled in the following IDLE cycle.
- ch_be=0 still performs the access; mem_be=0 is passed through unchanged.
- Arbitration when several ch_req are high in IDLE: see Configuration.

## Timing
- Reset (reset=0 at a posedge): state→IDLE, wait counter→0, RR pointer→P_NUM_CH-1. All outputs go to 0: ch_ready, ch_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata.
- Reset mid-transaction: the access is dropped, no ready is issued, and no mem_en follows.
- Latency: request sampled in IDLE at cycle 0. mem_en is high in cycle 1+W and ch_ready in cycle 2+W (W = P_WAIT_CYCLES).
- Throughput: one transaction per 3+W cycles.
- At most one ch_ready bit is high in any cycle. ch_ready is never high in two consecutive cycles.

## Configuration
- RISCV_MEM_RR_EN defined: round-robin arbitration. The search starts at the index after the last granted channel and wraps modulo P_NUM_CH. The pointer updates on each grant.
- RISCV_MEM_RR_EN undefined: fixed priority, lowest index wins. ch0 (fetch) can starve higher channels. No pointer register is built.

## Test plan
- Reset with P_WAIT_CYCLES=1: reset=0 for 2 cycles with ch_req=2'b11 → all outputs 0 and no mem_en. After release, ch0 is granted first in both modes.
- Read, W=2: SRAM[0x40]=0xDEADBEEF, ch1 read at 0x40 in cycle 0 → mem_en high only in cycle 3, ch_ready[1] high only in cycle 4. ch_rdata[1]=0xDEADBEEF in cycle 4 and held afterwards.
- Write with byte enables: ch1 writes addr 0x10, be=4'b0011, wdata 0x12345678 over old 0xAAAAAAAA → one cycle with mem_we=1 and mem_be=0011. Read-back returns 0xAAAA5678.
- Contention, both channels requesting continuously for 4 transactions: with RISCV_MEM_RR_EN, grants are 0,1,0,1. Without it, grants are 0,0,0,0.
- Reset during WAIT (W=3, reset=0 in cycle 2): no mem_en and no ch_ready follow. The re-issued request completes with normal latency.
- W=0: ch0 read in cycle 0 → mem_en in cycle 1, ch_ready[0] in cycle 2. A request deasserted in cycle 1 still gets ready in cycle 2.
